// File: rtl/input_scan_loader.sv
// Packs a narrow valid/ready beat stream into data/weight SRAM words and writes them
// over the scan port, holding the convolution core in reset until every address is loaded.
module input_scan_loader #(
    parameter int BEAT_W    = 32,
    parameter int WORD_W    = 512,
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              input_mem_scan_mode,
    output logic              scan_we,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [WORD_W-1:0] data_mem_scan_in,
    output logic [WORD_W-1:0] weight_mem_scan_in,
    output logic              core_reset,
    output logic              load_done,
    output logic [4:0]        state_dbg
);

    localparam int BEATS = WORD_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    // One-hot so every output decode is a single flop or a small OR of flops.
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_FILL_D = 5'b00010,
        S_FILL_W = 5'b00100,
        S_COMMIT = 5'b01000,
        S_DONE   = 5'b10000
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_fire;
    logic             last_beat;

    // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid, and in_data is ignored otherwise.
    assign beat_fire = in_valid && in_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_FILL_D;
                end
            end
            S_FILL_D: begin
                if (beat_fire && last_beat) begin
                    state_nxt = S_FILL_W;
                end
            end
            S_FILL_W: begin
                if (beat_fire && last_beat) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_nxt = (scan_addr == LAST_ADDR) ? S_DONE : S_FILL_D;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready            = 1'b0;
        input_mem_scan_mode = 1'b0;
        scan_we             = 1'b0;
        case (state)
            S_FILL_D, S_FILL_W: begin
                in_ready            = 1'b1;
                input_mem_scan_mode = 1'b1;
            end
            S_COMMIT: begin
                scan_we             = 1'b1;
                input_mem_scan_mode = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // core_reset/load_done come straight from flops fed by the next state, so they
    // change exactly on the edge that enters or leaves DONE with no decode glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            core_reset <= (state_nxt != S_DONE);
            load_done  <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt           <= '0;
            scan_addr          <= '0;
            data_mem_scan_in   <= '0;
            weight_mem_scan_in <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        scan_addr <= '0;
                        beat_cnt  <= '0;
                    end
                end
                S_FILL_D: begin
                    if (beat_fire) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CNT_W'(k)) begin
                                data_mem_scan_in[k*BEAT_W +: BEAT_W] <= in_data;
                            end
                        end
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                S_FILL_W: begin
                    if (beat_fire) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CNT_W'(k)) begin
                                weight_mem_scan_in[k*BEAT_W +: BEAT_W] <= in_data;
                            end
                        end
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    // The final address is held in DONE rather than wrapping to zero.
                    if (scan_addr != LAST_ADDR) begin
                        scan_addr <= scan_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_scan_loader.sv
// Bench for input_scan_loader: control-point table, full loads with and without
// in_valid gaps, start handling, and asynchronous reset in the middle of a load.
module tb_input_scan_loader;

    localparam int BEAT_W    = 32;
    localparam int WORD_W    = 512;
    localparam int ADDR_W    = 8;
    localparam int NUM_WORDS = 128;
    localparam int BEATS     = WORD_W / BEAT_W;
    localparam int PERIOD    = 2 * BEATS + 1;
    localparam int NO_STOP   = 1 << 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [BEAT_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              input_mem_scan_mode;
    logic              scan_we;
    logic [ADDR_W-1:0] scan_addr;
    logic [WORD_W-1:0] data_mem_scan_in;
    logic [WORD_W-1:0] weight_mem_scan_in;
    logic              core_reset;
    logic              load_done;
    logic [4:0]        state_dbg;

    always #5 clk = ~clk;

    input_scan_loader #(
        .BEAT_W(BEAT_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .input_mem_scan_mode(input_mem_scan_mode), .scan_we(scan_we),
        .scan_addr(scan_addr), .data_mem_scan_in(data_mem_scan_in),
        .weight_mem_scan_in(weight_mem_scan_in), .core_reset(core_reset),
        .load_done(load_done), .state_dbg(state_dbg)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Scoreboard: one entry {addr, data word, weight word} per expected SRAM write.
    logic [ADDR_W+2*WORD_W-1:0] exp_q[$];
    logic [BEAT_W-1:0]          beat_q[$];
    logic [WORD_W-1:0] ref_d[NUM_WORDS];
    logic [WORD_W-1:0] ref_w[NUM_WORDS];
    logic [WORD_W-1:0] img_d[NUM_WORDS];
    logic [WORD_W-1:0] img_w[NUM_WORDS];
    logic [WORD_W-1:0] img1_d[NUM_WORDS];
    logic [WORD_W-1:0] img1_w[NUM_WORDS];
    bit     sb_en     = 1'b0;
    bit     gap_chk   = 1'b0;
    bit     prev_last = 1'b0;
    int     commit_cnt = 0;
    int     beats_acc  = 0;
    longint cyc        = 0;
    longint last_we    = -1;

    task automatic chk(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: SRAM model on the scan port, scoreboard, and cycle-level invariants.
    initial forever begin
        logic [ADDR_W+2*WORD_W-1:0] e;
        @(negedge clk);
        if (!reset) begin
            chk("ready_only_in_fill", in_ready && (scan_we || load_done || !input_mem_scan_mode), 0);
            chk("core_reset_vs_done", core_reset, !load_done);
            chk("state_dbg_onehot", $onehot(state_dbg), 1);
            if (prev_last) begin
                chk("end_load_done", load_done, 1);
                chk("end_core_reset", core_reset, 0);
                chk("end_scan_mode", input_mem_scan_mode, 0);
                chk("end_scan_we", scan_we, 0);
                chk("end_addr_hold", scan_addr, NUM_WORDS - 1);
            end
            prev_last = scan_we && (scan_addr == ADDR_W'(NUM_WORDS - 1));
            if (scan_we) begin
                commit_cnt++;
                if (scan_addr < NUM_WORDS) begin
                    img_d[scan_addr] = data_mem_scan_in;
                    img_w[scan_addr] = weight_mem_scan_in;
                end
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL sb_write: got write at addr %0d expected none", scan_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_addr", scan_addr, e[ADDR_W+2*WORD_W-1 -: ADDR_W]);
                        chk("sb_data", data_mem_scan_in, e[2*WORD_W-1 -: WORD_W]);
                        chk("sb_weight", weight_mem_scan_in, e[WORD_W-1:0]);
                    end
                end
                if (gap_chk && last_we >= 0) chk("we_spacing", cyc - last_we, PERIOD);
                last_we = cyc;
            end
        end else begin
            prev_last = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    // Reference model: build each whole word first, then split it into the beat stream.
    task automatic build_stream(input bit rnd);
        logic [WORD_W-1:0] dw;
        logic [WORD_W-1:0] ww;
        logic [BEAT_W-1:0] v;
        beat_q.delete();
        exp_q.delete();
        for (int a = 0; a < NUM_WORDS; a++) begin
            for (int k = 0; k < BEATS; k++) begin
                v = rnd ? BEAT_W'($urandom) : BEAT_W'(a * BEATS + k);
                dw[k*BEAT_W +: BEAT_W] = v;
                ww[k*BEAT_W +: BEAT_W] = rnd ? BEAT_W'($urandom) : ~v;
            end
            for (int k = 0; k < BEATS; k++) beat_q.push_back(dw[k*BEAT_W +: BEAT_W]);
            for (int k = 0; k < BEATS; k++) beat_q.push_back(ww[k*BEAT_W +: BEAT_W]);
            exp_q.push_back({ADDR_W'(a), dw, ww});
            ref_d[a] = dw;
            ref_w[a] = ww;
        end
    endtask

    // Driver: offers beats with gap_pct% idle cycles; stops early after stop_commits writes.
    task automatic run_load(input int gap_pct, input bit hold_start, input int stop_commits);
        int budget;
        bit first;
        budget = 0;
        first = 1'b1;
        commit_cnt = 0;
        beats_acc = 0;
        while (beat_q.size() > 0 && commit_cnt < stop_commits && budget < 20000) begin
            @(negedge clk);
            start = first || hold_start;
            first = 1'b0;
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data = in_valid ? beat_q[0] : BEAT_W'($urandom);
            if (in_valid && in_ready) begin
                void'(beat_q.pop_front());
                beats_acc++;
            end
            budget++;
        end
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        if (commit_cnt < stop_commits) begin
            chk("stream_drained", beat_q.size(), 0);
            budget = 0;
            while (!load_done && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            chk("load_done_reached", load_done, 1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "/in_ready"}, in_ready, 0);
        chk({tag, "/scan_mode"}, input_mem_scan_mode, 0);
        chk({tag, "/scan_we"}, scan_we, 0);
        chk({tag, "/scan_addr"}, scan_addr, 0);
        chk({tag, "/data_word"}, data_mem_scan_in, 0);
        chk({tag, "/weight_word"}, weight_mem_scan_in, 0);
        chk({tag, "/core_reset"}, core_reset, 1);
        chk({tag, "/load_done"}, load_done, 0);
    endtask

    task automatic check_images(input string tag, input bit against_img1);
        for (int a = 0; a < NUM_WORDS; a++) begin
            chk({tag, "_data"}, img_d[a], against_img1 ? img1_d[a] : ref_d[a]);
            chk({tag, "_weight"}, img_w[a], against_img1 ? img1_w[a] : ref_w[a]);
        end
    endtask

    typedef struct {
        bit start;
        bit valid;
        int reps;
        bit exp_ready;
        bit exp_mode;
        bit exp_we;
        bit exp_cr;
        bit exp_done;
        int exp_addr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, 0, 1,  0, 0, 0, 1, 0, 0};
        tbl[1] = '{1, 0, 1,  1, 1, 0, 1, 0, 0};
        tbl[2] = '{1, 0, 5,  1, 1, 0, 1, 0, 0};
        tbl[3] = '{0, 1, 16, 1, 1, 0, 1, 0, 0};
        tbl[4] = '{1, 1, 15, 1, 1, 0, 1, 0, 0};
        tbl[5] = '{0, 0, 3,  1, 1, 0, 1, 0, 0};
        tbl[6] = '{1, 1, 1,  0, 1, 1, 1, 0, 0};
        tbl[7] = '{1, 1, 1,  1, 1, 0, 1, 0, 1};
        tbl[8] = '{0, 1, 1,  1, 1, 0, 1, 0, 1};

        do_reset();
        check_reset_vals("por");

        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                start = tbl[i].start;
                in_valid = tbl[i].valid;
                in_data = BEAT_W'($urandom);
                @(negedge clk);
            end
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_scan_mode", i), input_mem_scan_mode, tbl[i].exp_mode);
            chk($sformatf("tbl%0d_scan_we", i), scan_we, tbl[i].exp_we);
            chk($sformatf("tbl%0d_core_reset", i), core_reset, tbl[i].exp_cr);
            chk($sformatf("tbl%0d_load_done", i), load_done, tbl[i].exp_done);
            chk($sformatf("tbl%0d_scan_addr", i), scan_addr, tbl[i].exp_addr);
        end
        do_reset();
        check_reset_vals("post_table");

        // Full load, in_valid always high: writes exactly PERIOD cycles apart.
        build_stream(1'b0);
        sb_en = 1'b1;
        gap_chk = 1'b1;
        last_we = -1;
        run_load(0, 1'b0, NO_STOP);
        gap_chk = 1'b0;
        chk("t1_commits", commit_cnt, NUM_WORDS);
        chk("t1_beats", beats_acc, NUM_WORDS * 2 * BEATS);
        check_images("t1_image", 1'b0);
        for (int a = 0; a < NUM_WORDS; a++) begin
            img1_d[a] = img_d[a];
            img1_w[a] = img_w[a];
            img_d[a] = '0;
            img_w[a] = '0;
        end

        // Same stream with 30% in_valid gaps must yield the identical image.
        build_stream(1'b0);
        run_load(30, 1'b0, NO_STOP);
        chk("t2_commits", commit_cnt, NUM_WORDS);
        chk("t2_beats", beats_acc, NUM_WORDS * 2 * BEATS);
        check_images("t2_image", 1'b1);

        // start held high during the load must not restart it.
        build_stream(1'b1);
        run_load(0, 1'b1, NO_STOP);
        chk("t4_commits", commit_cnt, NUM_WORDS);
        check_images("t4_image_a", 1'b0);

        // Re-pulse start in DONE: full reload of a second image.
        build_stream(1'b1);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("t4_restart_core_reset", core_reset, 1);
        chk("t4_restart_load_done", load_done, 0);
        chk("t4_restart_addr", scan_addr, 0);
        chk("t4_restart_ready", in_ready, 1);
        run_load(10, 1'b0, NO_STOP);
        chk("t4_reload_commits", commit_cnt, NUM_WORDS);
        check_images("t4_image_b", 1'b0);

        // Asynchronous reset after 40 words, then a fresh load from address 0.
        build_stream(1'b0);
        run_load(0, 1'b0, 40);
        chk("t5_partial_commits", commit_cnt >= 40, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midload_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("after_midload_reset");
        build_stream(1'b0);
        run_load(20, 1'b0, NO_STOP);
        chk("t5_reload_commits", commit_cnt, NUM_WORDS);
        chk("t5_queue_empty", exp_q.size(), 0);
        check_images("t5_image", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
